// File: rtl/quad_step_decoder.sv
// Quadrature A/B step decoder: synchronises the phase inputs, decodes Gray-code
// transitions into up/down steps and keeps a wrap-around position count.
module quad_step_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TR_NONE    = 2'b00,
    TR_UP      = 2'b01,
    TR_DOWN    = 2'b10,
    TR_ILLEGAL = 2'b11
  } trans_t;

  localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  // Classify a {A,B} transition; up order is 00->10->11->01->00.
  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    trans_t t;
    case ({prev, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: t = TR_UP;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: t = TR_DOWN;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: t = TR_ILLEGAL;
      default:                            t = TR_NONE;
    endcase
    return t;
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_r;
  logic [SYNC_STAGES-1:0] b_sync_r;
  logic [1:0]             cur_s;
  trans_t                 trans_s;

  state_t           state_r,    state_nxt_s;
  logic [2:0]       init_cnt_r, init_cnt_nxt_s;
  logic [1:0]       prev_r,     prev_nxt_s;
  logic [WIDTH-1:0] count_r,    count_nxt_s;
  logic             dir_r,      dir_nxt_s;
  logic             step_r,     step_nxt_s;
  logic             wrap_r,     wrap_nxt_s;
  logic             err_r,      err_nxt_s;

  // Plain flop chains bring the asynchronous phases into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_r <= {SYNC_STAGES{1'b0}};
      b_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], a_in};
      b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], b_in};
    end
  end

  assign cur_s   = {a_sync_r[SYNC_STAGES-1], b_sync_r[SYNC_STAGES-1]};
  assign trans_s = classify(prev_r, cur_s);

  // Next-state: INIT waits out pipeline fill, RUN decodes; clear overrides outputs.
  always_comb begin
    state_nxt_s    = state_r;
    init_cnt_nxt_s = init_cnt_r;
    prev_nxt_s     = cur_s;
    count_nxt_s    = count_r;
    dir_nxt_s      = dir_r;
    step_nxt_s     = 1'b0;
    wrap_nxt_s     = 1'b0;
    err_nxt_s      = err_r;

    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == INIT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          init_cnt_nxt_s = init_cnt_r + 3'd1;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase

    if (clear) begin
      count_nxt_s = CNT_ZERO;
      err_nxt_s   = 1'b0;
      step_nxt_s  = 1'b0;
      wrap_nxt_s  = 1'b0;
    end else if (state_r == ST_RUN) begin
      case (trans_s)
        TR_UP: begin
          count_nxt_s = count_r + CNT_ONE;
          dir_nxt_s   = 1'b1;
          step_nxt_s  = 1'b1;
          wrap_nxt_s  = (count_r == CNT_MAX);
        end
        TR_DOWN: begin
          count_nxt_s = count_r - CNT_ONE;
          dir_nxt_s   = 1'b0;
          step_nxt_s  = 1'b1;
          wrap_nxt_s  = (count_r == CNT_ZERO);
        end
        TR_ILLEGAL: err_nxt_s  = 1'b1;
        default:    step_nxt_s = 1'b0;
      endcase
    end else begin
      step_nxt_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 3'd0;
      prev_r     <= 2'b00;
      count_r    <= CNT_ZERO;
      dir_r      <= 1'b0;
      step_r     <= 1'b0;
      wrap_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      init_cnt_r <= init_cnt_nxt_s;
      prev_r     <= prev_nxt_s;
      count_r    <= count_nxt_s;
      dir_r      <= dir_nxt_s;
      step_r     <= step_nxt_s;
      wrap_r     <= wrap_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign count = count_r;
  assign dir   = dir_r;
  assign step  = step_r;
  assign wrap  = wrap_r;
  assign err   = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus a random quadrature walk,
// all checked every cycle against a history-based position model.
module tb_quad_step_decoder;

  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             a_in  = 1'b0;
  logic             b_in  = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] count;
  logic             dir, step, wrap, err;

  int checks   = 0;
  int failures = 0;

  quad_step_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clear(clear),
    .count(count), .dir(dir), .step(step), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: position of each Gray state around the cycle.
  int         m_count = 0;
  int         m_dir = 0, m_step = 0, m_wrap = 0, m_err = 0;
  int         edges = 0;
  logic [1:0] hist[$];

  function automatic int gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_update();
    int d;
    if (!rst_n) begin
      m_count = 0; m_dir = 0; m_step = 0; m_wrap = 0; m_err = 0;
      edges = 0;
      hist.delete();
    end else begin
      edges++;
      hist.push_back({a_in, b_in});
      if (hist.size() > S + 2) void'(hist.pop_front());
      m_step = 0;
      m_wrap = 0;
      if (clear) begin
        m_count = 0;
        m_err   = 0;
      end else if (edges >= S + 2) begin
        // hist[0]/hist[1] are the inputs sampled S+1 and S edges ago.
        d = (gray_pos(hist[1]) - gray_pos(hist[0]) + 4) % 4;
        if (d == 1) begin
          m_wrap  = (m_count == MAXV);
          m_count = (m_count + 1) % (MAXV + 1);
          m_dir   = 1;
          m_step  = 1;
        end else if (d == 3) begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + MAXV) % (MAXV + 1);
          m_dir   = 0;
          m_step  = 1;
        end else if (d == 2) begin
          m_err = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_update();
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_count", int'(count), m_count);
    check("model_dir",   int'(dir),   m_dir);
    check("model_step",  int'(step),  m_step);
    check("model_wrap",  int'(wrap),  m_wrap);
    check("model_err",   int'(err),   m_err);
  end

  task automatic move(input logic [1:0] ab, input int hold, output int sc, output int ws);
    a_in = ab[1];
    b_in = ab[0];
    sc = 0;
    ws = 0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (step === 1'b1 && sc == 0) sc = i;
      if (wrap === 1'b1) ws = 1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [1:0] up_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] dn_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] pos2ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int t3_cnt [4] = '{255, 254, 253, 252};
  int t3_wrp [4] = '{1, 0, 0, 0};
  int t4_cnt [4] = '{253, 254, 255, 0};
  int t4_wrp [4] = '{0, 0, 0, 1};

  initial begin
    int sc, ws, p, r, hold;
    bit do_clr, do_rst;

    // Reset release with both phases high: INIT must absorb the pipeline fill.
    a_in = 1'b1; b_in = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    move(2'b11, 8, sc, ws);
    check("t1_no_step", sc, 0);
    check("t1_count", int'(count), 0);
    check("t1_err", int'(err), 0);
    move(2'b01, 4, sc, ws);
    move(2'b00, 4, sc, ws);
    check("t1_two_up", int'(count), 2);
    pulse_clear();
    check("t1_clear", int'(count), 0);

    // Four up steps, each SYNC_STAGES+1 cycles after its input edge.
    for (int i = 0; i < 4; i++) begin
      move(up_seq[i], 4, sc, ws);
      check("t2_latency", sc, 3);
    end
    check("t2_count", int'(count), 4);
    check("t2_dir", int'(dir), 1);
    pulse_clear();

    // Down from zero wraps to all-ones.
    for (int i = 0; i < 4; i++) begin
      move(dn_seq[i], 4, sc, ws);
      check("t3_count", int'(count), t3_cnt[i]);
      check("t3_wrap", ws, t3_wrp[i]);
    end
    check("t3_dir", int'(dir), 0);

    // Up through 255 -> 0: wrap only on that step.
    for (int i = 0; i < 4; i++) begin
      move(up_seq[i], 4, sc, ws);
      check("t4_count", int'(count), t4_cnt[i]);
      check("t4_wrap", ws, t4_wrp[i]);
    end

    // Illegal 00->11, then a legal step with err sticky, then clear.
    move(2'b11, 4, sc, ws);
    check("t5_no_step", sc, 0);
    check("t5_err", int'(err), 1);
    check("t5_count", int'(count), 0);
    move(2'b01, 4, sc, ws);
    check("t5_count_up", int'(count), 1);
    check("t5_err_sticky", int'(err), 1);
    pulse_clear();
    check("t5_clr_count", int'(count), 0);
    check("t5_clr_err", int'(err), 0);
    check("t5_dir_held", int'(dir), 1);

    // Clear on the very edge that decodes a legal step.
    a_in = 1'b0; b_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    check("t6_clr_step", int'(step), 0);
    check("t6_clr_count", int'(count), 0);
    clear = 1'b0;
    @(negedge clk);
    move(2'b10, 4, sc, ws);
    check("t6_count", int'(count), 1);

    // Reset mid-sequence clears outputs at once; INIT then rebaselines on 10.
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_dir", int'(dir), 0);
    check("t6_rst_step", int'(step), 0);
    check("t6_rst_wrap", int'(wrap), 0);
    check("t6_rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    move(2'b10, 8, sc, ws);
    check("t6_reinit_step", sc, 0);
    check("t6_reinit_count", int'(count), 0);

    // Random walk with occasional illegal jumps, clears and resets.
    p = 1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)       p = (p + 2) % 4;
      else if (r < 10)  p = (p + 1) % 4;
      else              p = (p + 3) % 4;
      a_in = pos2ab[p][1];
      b_in = pos2ab[p][0];
      hold   = $urandom_range(3, 6);
      do_clr = ($urandom_range(0, 15) == 0);
      do_rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < hold; i++) begin
        clear = do_clr && (i == 1);
        @(negedge clk);
      end
      clear = 1'b0;
      if (do_rst) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Receive side of a two-wire quadrature (Gray-coded A/B) step interface, as driven by a rotary encoder or stepper feedback.
- Synchronises the asynchronous A/B inputs and decodes each legal transition into one up or down step.
- Maintains a wrap-around WIDTH-bit up/down position count, plus per-step direction and pulse flags.
- Flags illegal double-bit transitions for the system controller.

Parameters:
WIDTH, 8, width of the position counter (valid range 2 to 32)
SYNC_STAGES, 2, number of synchroniser flops on each of a_in and b_in (valid range 2 to 4)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronous to clk
a_in  input  1  quadrature phase A, asynchronous to clk
b_in  input  1  quadrature phase B, asynchronous to clk
clear  input  1  synchronous clear of count and err; level-sensitive
count  output  WIDTH  current position count
dir  output  1  direction of the most recent legal step; 1 = up, 0 = down
step  output  1  one-cycle pulse on every legal step
wrap  output  1  one-cycle pulse when count wraps (max to 0 going up, or 0 to max going down)
err  output  1  sticky flag, set on an illegal transition

Behaviour:
- Reset (rst_n = 0): the following all go to 0 asynchronously:
  - synchroniser flops, prev-state register {pa,pb}, count, dir, step, wrap, err
  - the init cycle counter
  - FSM goes to INIT.
- Synchroniser: SYNC_STAGES flops per input, no logic between them. Synchronised values are sa and sb.
- FSM states:
  - INIT: on each cycle, load {pa,pb} <= {sa,sb} and perform no decoding. After SYNC_STAGES+1 cycles in INIT, move to RUN. This prevents a false step or err caused by pipeline fill when the inputs are not 00 at reset release.
  - RUN: compare cur = {sa,sb} with prev = {pa,pb} every cycle, then load prev <= cur.
- Decode in RUN, with {A,B} as the 2-bit state:
  - Up sequence: 00->10->11->01->00.
  - Down sequence: the reverse, 00->01->11->10->00.
  - cur == prev: no action.
  - Legal up: count <= count+1, dir <= 1, step pulse.
  - Legal down: count <= count-1, dir <= 0, step pulse.
  - Both bits differ (00<->11, 10<->01): illegal. err <= 1, no count change, no step, dir unchanged.
- Arithmetic: modulo 2^WIDTH.
  - Up from all-ones gives 0 with a wrap pulse.
  - Down from 0 gives all-ones with a wrap pulse.
  - wrap is asserted in the same cycle as the corresponding step.
- Registered outputs and latency: step, wrap, count, dir and err are all registered.
  - An input edge reaches sa/sb after SYNC_STAGES clk edges.
  - count, step and dir update on the following edge, giving SYNC_STAGES+1 cycles total.
- clear: has priority over a step in the same cycle.
  - count <= 0, err <= 0, step <= 0, wrap <= 0; dir is held.
  - The prev register still loads cur, so the transition is consumed, not deferred.
  - clear is honoured in INIT as well.
- err: once set, stays 1 until clear or reset. Later legal steps continue to count normally.
- Input rate: inputs must hold each state at least SYNC_STAGES+1 cycles. Faster input is out of scope and is detected only if it produces a double-bit change.
- Reset mid-operation: all state is lost and INIT repeats. The first RUN cycle uses the inputs present at that time as the baseline.

Test Plan:
1. Reset release with a_in=b_in=1 held, WIDTH=8 -> after INIT no step, count=0, err=0.
2. Four up steps 00->10->11->01->00, each held 4 cycles -> four step pulses, dir=1, count=4, each step SYNC_STAGES+1=3 cycles after its input edge.
3. Four down steps from count=0 -> first step gives count=255 with wrap=1 in the same cycle; final count=252, dir=0.
4. Up steps from count=254 -> counts 255 then 0; wrap pulses only on the 255->0 step.
5. Force 00->11 directly -> err=1, count unchanged, no step. Then one legal up step 11->01 -> count+1 with err still 1. Pulse clear -> count=0, err=0.
6. Assert clear in the same cycle a legal step is decoded -> count=0, no step pulse. Deassert rst_n mid-sequence -> all outputs 0 immediately, INIT repeats.
